// File: rtl/fetch_decode.sv
// Two-phase instruction sequencer for the accumulator datapath.
// Each instruction takes a FETCH cycle, where the program memory read is in
// flight, and then one EXEC cycle, where the returned word is decoded into
// datapath strobes. OP_HEI ("halt until external input") holds EXEC until
// the synchronised SW8 differs from operand bit 0.
module fetch_decode #(
  parameter int PROG_LEN = 24
) (
  input  logic        clk,
  input  logic        reset,
  output logic [4:0]  addr,
  input  logic [11:0] instruction,
  input  logic        sw8,
  output logic        acc_we,
  output logic [1:0]  acc_sel,
  output logic [1:0]  alu_op,
  output logic        imm_sel,
  output logic [4:0]  imm,
  output logic        reg_we,
  output logic [4:0]  reg_addr,
  output logic        stalled
);

  // Shared opcode definitions; 7'd0 is deliberately left unassigned so an
  // erased or zero-filled memory word decodes as a harmless no-op.
  localparam logic [6:0] OP_HEI  = 7'd1;
  localparam logic [6:0] OP_LSW  = 7'd2;
  localparam logic [6:0] OP_RTA  = 7'd3;
  localparam logic [6:0] OP_ATR  = 7'd4;
  localparam logic [6:0] OP_ADD  = 7'd5;
  localparam logic [6:0] OP_ADDI = 7'd6;
  localparam logic [6:0] OP_MULI = 7'd7;

  localparam logic [1:0] SEL_ALU = 2'd0;
  localparam logic [1:0] SEL_SW  = 2'd1;
  localparam logic [1:0] SEL_RF  = 2'd2;

  localparam logic [1:0] ALU_PASS = 2'd0;
  localparam logic [1:0] ALU_ADD  = 2'd1;
  localparam logic [1:0] ALU_MUL  = 2'd2;

  localparam logic [4:0] LAST_PC = 5'(PROG_LEN - 1);

  typedef enum logic {
    FETCH = 1'b0,
    EXEC  = 1'b1
  } state_t;

  state_t     state;
  state_t     next_state;
  logic [4:0] pc;
  logic [4:0] pc_next;
  logic       sw8_m;
  logic       sw8_s;

  logic [6:0] opcode;
  logic [4:0] operand;

  assign opcode   = instruction[11:5];
  assign operand  = instruction[4:0];
  assign imm      = operand;
  assign reg_addr = operand;
  assign addr     = reset ? 5'd0 : pc;

  // Two-flop synchroniser for the asynchronous handshake switch.
  always_ff @(posedge clk) begin
    if (reset) begin
      sw8_m <= 1'b0;
      sw8_s <= 1'b0;
    end else begin
      sw8_m <= sw8;
      sw8_s <= sw8_m;
    end
  end

  // Sequencer state and program counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FETCH;
      pc    <= 5'd0;
    end else begin
      state <= next_state;
      pc    <= pc_next;
    end
  end

  // Next-state, PC advance and instruction decode; strobes only in EXEC.
  always_comb begin
    next_state = state;
    pc_next    = pc;
    acc_we     = 1'b0;
    acc_sel    = SEL_ALU;
    alu_op     = ALU_PASS;
    imm_sel    = 1'b0;
    reg_we     = 1'b0;
    stalled    = 1'b0;

    if (!reset) begin
      unique case (state)
        FETCH: begin
          next_state = EXEC;
        end
        EXEC: begin
          case (opcode)
            OP_LSW: begin
              acc_we  = 1'b1;
              acc_sel = SEL_SW;
            end
            OP_RTA: begin
              acc_we  = 1'b1;
              acc_sel = SEL_RF;
            end
            OP_ATR: begin
              reg_we = 1'b1;
            end
            OP_ADD: begin
              acc_we  = 1'b1;
              acc_sel = SEL_ALU;
              alu_op  = ALU_ADD;
              imm_sel = 1'b0;
            end
            OP_ADDI: begin
              acc_we  = 1'b1;
              acc_sel = SEL_ALU;
              alu_op  = ALU_ADD;
              imm_sel = 1'b1;
            end
            OP_MULI: begin
              acc_we  = 1'b1;
              acc_sel = SEL_ALU;
              alu_op  = ALU_MUL;
              imm_sel = 1'b1;
            end
            default: begin
            end
          endcase

          if ((opcode == OP_HEI) && (sw8_s == operand[0])) begin
            stalled = 1'b1;
          end else begin
            next_state = FETCH;
            pc_next    = (pc == LAST_PC) ? 5'd0 : pc + 5'd1;
          end
        end
        default: begin
          next_state = FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_decode.sv
// Randomised self-checking bench for fetch_decode with a registered program
// memory and a cycle-level behavioural model of the instruction sequence.
module tb_fetch_decode;

  localparam int PROG_LEN = 24;

  localparam logic [6:0] OP_HEI  = 7'd1;
  localparam logic [6:0] OP_LSW  = 7'd2;
  localparam logic [6:0] OP_RTA  = 7'd3;
  localparam logic [6:0] OP_ATR  = 7'd4;
  localparam logic [6:0] OP_ADD  = 7'd5;
  localparam logic [6:0] OP_ADDI = 7'd6;
  localparam logic [6:0] OP_MULI = 7'd7;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sw8 = 1'b0;
  logic [11:0] instruction = 12'd0;
  logic [4:0]  addr;
  logic        acc_we;
  logic [1:0]  acc_sel;
  logic [1:0]  alu_op;
  logic        imm_sel;
  logic [4:0]  imm;
  logic        reg_we;
  logic [4:0]  reg_addr;
  logic        stalled;

  logic [11:0] prog [PROG_LEN];

  int checks = 0;
  int errors = 0;

  // Reference model: which word is executing, whether its memory read has
  // returned yet, and the last two SW8 samples taken at clock edges.
  int m_pc = 0;
  bit m_exec = 1'b0;
  bit sw_seen_last = 1'b0;
  bit sw_seen_prev = 1'b0;
  int wraps = 0;

  fetch_decode #(.PROG_LEN(PROG_LEN)) dut (
    .clk(clk),
    .reset(reset),
    .addr(addr),
    .instruction(instruction),
    .sw8(sw8),
    .acc_we(acc_we),
    .acc_sel(acc_sel),
    .alu_op(alu_op),
    .imm_sel(imm_sel),
    .imm(imm),
    .reg_we(reg_we),
    .reg_addr(reg_addr),
    .stalled(stalled)
  );

  always #5 clk = ~clk;

  // Program memory with one clock of read latency.
  always @(posedge clk) instruction <= prog[addr];

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d (t=%0t pc=%0d)", tag, observed, expected, $time, m_pc);
    end
  endtask

  // Expected strobes for one instruction word: {acc_we, acc_sel, alu_op, imm_sel, reg_we}.
  function automatic logic [6:0] expectedDecode(input logic [11:0] w);
    logic [6:0] r;
    r = 7'd0;
    case (w[11:5])
      OP_LSW:  r = {1'b1, 2'd1, 2'd0, 1'b0, 1'b0};
      OP_RTA:  r = {1'b1, 2'd2, 2'd0, 1'b0, 1'b0};
      OP_ATR:  r = {1'b0, 2'd0, 2'd0, 1'b0, 1'b1};
      OP_ADD:  r = {1'b1, 2'd0, 2'd1, 1'b0, 1'b0};
      OP_ADDI: r = {1'b1, 2'd0, 2'd1, 1'b1, 1'b0};
      OP_MULI: r = {1'b1, 2'd0, 2'd2, 1'b1, 1'b0};
      default: r = 7'd0;
    endcase
    return r;
  endfunction

  // One clock: drive inputs, compare outputs with the model, then advance the model.
  task automatic applyStimulus(input bit r, input bit s);
    logic [6:0]  e_dec;
    logic [4:0]  e_imm;
    logic [4:0]  e_addr;
    bit          e_stall;
    logic [11:0] w;
    reset = r;
    sw8   = s;
    #1;
    e_dec   = 7'd0;
    e_stall = 1'b0;
    e_addr  = r ? 5'd0 : 5'(m_pc);
    e_imm   = instruction[4:0];
    if (!r && m_exec) begin
      w       = prog[m_pc];
      e_dec   = expectedDecode(w);
      e_imm   = w[4:0];
      e_stall = (w[11:5] == OP_HEI) && (sw_seen_prev == w[0]);
    end
    checkOutput("addr",     addr,     e_addr);
    checkOutput("acc_we",   acc_we,   e_dec[6]);
    checkOutput("acc_sel",  acc_sel,  e_dec[5:4]);
    checkOutput("alu_op",   alu_op,   e_dec[3:2]);
    checkOutput("imm_sel",  imm_sel,  e_dec[1]);
    checkOutput("reg_we",   reg_we,   e_dec[0]);
    checkOutput("stalled",  stalled,  e_stall);
    checkOutput("imm",      imm,      e_imm);
    checkOutput("reg_addr", reg_addr, e_imm);
    @(posedge clk);
    if (r) begin
      m_pc         = 0;
      m_exec       = 1'b0;
      sw_seen_last = 1'b0;
      sw_seen_prev = 1'b0;
    end else begin
      if (!m_exec) begin
        m_exec = 1'b1;
      end else if (!e_stall) begin
        m_exec = 1'b0;
        if (m_pc == PROG_LEN - 1) begin
          m_pc = 0;
          wraps++;
        end else begin
          m_pc++;
        end
      end
      sw_seen_prev = sw_seen_last;
      sw_seen_last = s;
    end
    #1;
  endtask

  initial begin
    bit s;
    prog[0] = {OP_HEI,  5'd0};
    prog[1] = {OP_LSW,  5'd9};
    prog[2] = {OP_MULI, 5'd3};
    prog[3] = {OP_ATR,  5'd0};
    prog[4] = {OP_ADD,  5'd1};
    prog[5] = 12'd0;
    prog[6] = {OP_ADDI, 5'd17};
    prog[7] = {OP_HEI,  5'd1};
    for (int i = 8; i < PROG_LEN; i++) begin
      prog[i] = {7'($urandom_range(2, 7)), 5'($urandom)};
    end

    // Reset with SW8 high, then run: HEI 0 passes, HEI 1 at word 7 stalls.
    repeat (3) applyStimulus(1'b1, 1'b1);
    for (int n = 0; n < 100 && !(m_exec && m_pc == 7); n++) applyStimulus(1'b0, 1'b1);
    repeat (4) applyStimulus(1'b0, 1'b1);
    checkOutput("hei7_stalled", stalled, 1'b1);

    // One-cycle reset during the stall, then HEI 0 stalls with SW8 low.
    applyStimulus(1'b1, 1'b1);
    repeat (10) applyStimulus(1'b0, 1'b0);
    checkOutput("hei0_held_addr", addr, 5'd0);
    repeat (30) applyStimulus(1'b0, 1'b1);

    // Release word 7 and run off the end of the program to observe the wrap.
    for (int n = 0; n < 200 && wraps == 0; n++) applyStimulus(1'b0, 1'b0);
    checkOutput("wrap_addr", addr, 5'd0);
    checkOutput("wrap_seen", wraps, 1);

    // Random programs (including HEI and unassigned opcodes) with random SW8 and resets.
    for (int round = 0; round < 4; round++) begin
      applyStimulus(1'b1, sw8);
      for (int i = 0; i < PROG_LEN; i++) begin
        prog[i] = {7'($urandom_range(0, 9)), 5'($urandom)};
      end
      applyStimulus(1'b1, sw8);
      s = sw8;
      for (int n = 0; n < 400; n++) begin
        if ($urandom_range(0, 3) == 0) s = ~s;
        applyStimulus($urandom_range(0, 99) == 0, s);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
